// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC width and return-stack overflow policies,
// plus the encoding of the per-cycle stack operation.
package cpu_pkg;

  localparam int PC_WIDTH     = 12;
  localparam int OVF_SATURATE = 0;
  localparam int OVF_WRAP     = 1;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decodeOp(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address stack with combinational top-of-stack read, status outputs,
// selectable full-stack push policy and sticky overflow/underflow flags.
module call_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH    = PC_WIDTH,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = OVF_SATURATE
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic                       clrErr_i,
  input  logic [WIDTH-1:0]           writeData_i,
  output logic [WIDTH-1:0]           readData_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PW-1:0]    topIdx;
  logic             isFull, isEmpty;
  stack_op_e        op;

  // Pointer wraps naturally because DEPTH is a power of two.
  assign topIdx  = ptr_q - PW'(1);
  assign isFull  = (count_q == CW'(DEPTH));
  assign isEmpty = (count_q == '0);
  assign op      = decodeOp(push_i, pop_i);

  assign readData_o  = isEmpty ? '0 : mem_q[topIdx];
  assign count_o     = count_q;
  assign full_o      = isFull;
  assign empty_o     = isEmpty;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q & ~clrErr_i;
    unf_d   = unf_q & ~clrErr_i;
    if (flush_i) begin
      ptr_d   = '0;
      count_d = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (!isFull) begin
            mem_d[ptr_q] = writeData_i;
            ptr_d        = ptr_q + PW'(1);
            count_d      = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
            if (OVF_MODE == OVF_WRAP) begin
              mem_d[ptr_q] = writeData_i;
              ptr_d        = ptr_q + PW'(1);
            end
          end
        end
        OP_POP: begin
          if (!isEmpty) begin
            ptr_d   = topIdx;
            count_d = count_q - CW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        // Push+pop on an empty stack degrades to a plain push but still traps.
        OP_REPLACE: begin
          if (!isEmpty) begin
            mem_d[topIdx] = writeData_i;
          end else begin
            mem_d[ptr_q] = writeData_i;
            ptr_d        = ptr_q + PW'(1);
            count_d      = CW'(1);
            unf_d        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: one saturating and one wrapping instance
// share stimulus; each scenario task checks the instance it targets.
module tb_call_stack;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        push_i = 1'b0, pop_i = 1'b0, flush_i = 1'b0, clrErr_i = 1'b0;
  logic [11:0] writeData_i = '0;

  logic [11:0] rdS, rdW;
  logic [3:0]  cntS, cntW;
  logic        fullS, fullW, emptyS, emptyW, ovfS, ovfW, unfS, unfW;

  int checks = 0;
  int errors = 0;

  call_stack #(.WIDTH(12), .DEPTH(8), .OVF_MODE(OVF_SATURATE)) dutSat (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_i), .pop_i(pop_i),
    .flush_i(flush_i), .clrErr_i(clrErr_i), .writeData_i(writeData_i),
    .readData_o(rdS), .count_o(cntS), .full_o(fullS), .empty_o(emptyS),
    .overflow_o(ovfS), .underflow_o(unfS));

  call_stack #(.WIDTH(12), .DEPTH(8), .OVF_MODE(OVF_WRAP)) dutWrap (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_i), .pop_i(pop_i),
    .flush_i(flush_i), .clrErr_i(clrErr_i), .writeData_i(writeData_i),
    .readData_o(rdW), .count_o(cntW), .full_o(fullW), .empty_o(emptyW),
    .overflow_o(ovfW), .underflow_o(unfW));

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic pu, input logic po, input logic fl,
                               input logic ce, input logic [11:0] wd);
    push_i = pu; pop_i = po; flush_i = fl; clrErr_i = ce; writeData_i = wd;
    @(posedge clk_i);
    #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clrErr_i = 1'b0; writeData_i = '0;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({rdS, cntS, fullS, emptyS, ovfS, unfS} !== {12'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state rd=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b expected rd=000 cnt=0 full=0 empty=1 ovf=0 unf=0",
               rdS, cntS, fullS, emptyS, ovfS, unfS);
    end
  endtask

  task automatic test_push_pop();
    logic [11:0] expTop [3];
    expTop[0] = 12'h020; expTop[1] = 12'h010; expTop[2] = 12'h000;
    doReset();
    applyStimulus(1, 0, 0, 0, 12'h010);
    applyStimulus(1, 0, 0, 0, 12'h020);
    applyStimulus(1, 0, 0, 0, 12'h030);
    checks++;
    if (cntS !== 4'd3 || rdS !== 12'h030) begin
      errors++;
      $display("[TB] FAIL push3 cnt=%0d rd=%h expected cnt=3 rd=030", cntS, rdS);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, '0);
      checks++;
      if (rdS !== expTop[i]) begin
        errors++;
        $display("[TB] FAIL pop%0d rd=%h expected %h", i, rdS, expTop[i]);
      end
    end
    checks++;
    if (emptyS !== 1'b1 || cntS !== 4'd0 || unfS !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pop_empty empty=%b cnt=%0d unf=%b expected 1 0 0", emptyS, cntS, unfS);
    end
  endtask

  task automatic test_saturate();
    doReset();
    for (int v = 1; v <= 9; v++) applyStimulus(1, 0, 0, 0, 12'(v));
    checks++;
    if (cntS !== 4'd8 || fullS !== 1'b1 || rdS !== 12'd8 || ovfS !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_full cnt=%0d full=%b rd=%0d ovf=%b expected 8 1 8 1", cntS, fullS, rdS, ovfS);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdS !== 12'(8 - i)) begin
        errors++;
        $display("[TB] FAIL sat_pop%0d rd=%0d expected %0d", i, rdS, 8 - i);
      end
      applyStimulus(0, 1, 0, 0, '0);
    end
    checks++;
    if (emptyS !== 1'b1 || rdS !== 12'h000) begin
      errors++;
      $display("[TB] FAIL sat_drained empty=%b rd=%h expected 1 000", emptyS, rdS);
    end
  endtask

  task automatic test_wrap();
    doReset();
    for (int v = 1; v <= 10; v++) applyStimulus(1, 0, 0, 0, 12'(v));
    checks++;
    if (cntW !== 4'd8 || fullW !== 1'b1 || rdW !== 12'd10 || ovfW !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_full cnt=%0d full=%b rd=%0d ovf=%b expected 8 1 10 1", cntW, fullW, rdW, ovfW);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdW !== 12'(10 - i)) begin
        errors++;
        $display("[TB] FAIL wrap_pop%0d rd=%0d expected %0d", i, rdW, 10 - i);
      end
      applyStimulus(0, 1, 0, 0, '0);
    end
    checks++;
    if (emptyW !== 1'b1 || cntW !== 4'd0) begin
      errors++;
      $display("[TB] FAIL wrap_drained empty=%b cnt=%0d expected 1 0", emptyW, cntW);
    end
  endtask

  task automatic test_underflow();
    doReset();
    applyStimulus(0, 1, 0, 0, '0);
    checks++;
    if (unfS !== 1'b1 || cntS !== 4'd0 || ovfS !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unf_pop unf=%b cnt=%0d ovf=%b expected 1 0 0", unfS, cntS, ovfS);
    end
    applyStimulus(1, 1, 0, 0, 12'h055);
    checks++;
    if (cntS !== 4'd1 || rdS !== 12'h055 || unfS !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unf_pushpop cnt=%0d rd=%h unf=%b expected 1 055 1", cntS, rdS, unfS);
    end
    applyStimulus(0, 0, 0, 1, '0);
    checks++;
    if (unfS !== 1'b0 || ovfS !== 1'b0 || cntS !== 4'd1) begin
      errors++;
      $display("[TB] FAIL clr_err unf=%b ovf=%b cnt=%0d expected 0 0 1", unfS, ovfS, cntS);
    end
    // Clear and a fresh underflow in the same cycle: the set must win.
    applyStimulus(0, 1, 0, 0, '0);
    applyStimulus(0, 1, 0, 1, '0);
    checks++;
    if (unfS !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_vs_set unf=%b expected 1", unfS);
    end
  endtask

  task automatic test_replace_flush();
    doReset();
    applyStimulus(1, 0, 0, 0, 12'h100);
    applyStimulus(1, 0, 0, 0, 12'h200);
    applyStimulus(1, 1, 0, 0, 12'h2AA);
    checks++;
    if (cntS !== 4'd2 || rdS !== 12'h2AA || ovfS !== 1'b0 || unfS !== 1'b0) begin
      errors++;
      $display("[TB] FAIL replace cnt=%0d rd=%h ovf=%b unf=%b expected 2 2aa 0 0", cntS, rdS, ovfS, unfS);
    end
    applyStimulus(0, 1, 0, 0, '0);
    checks++;
    if (rdS !== 12'h100 || cntS !== 4'd1) begin
      errors++;
      $display("[TB] FAIL replace_pop rd=%h cnt=%0d expected 100 1", rdS, cntS);
    end
    applyStimulus(1, 0, 1, 0, 12'h3CC);
    checks++;
    if (cntS !== 4'd0 || rdS !== 12'h000 || emptyS !== 1'b1 || ovfS !== 1'b0 || unfS !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush cnt=%0d rd=%h empty=%b ovf=%b unf=%b expected 0 000 1 0 0",
               cntS, rdS, emptyS, ovfS, unfS);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(1, 0, 0, 0, 12'h0AB);
    checks++;
    if (rdS !== 12'h0AB) begin
      errors++;
      $display("[TB] FAIL call_visible rd=%h expected 0ab", rdS);
    end
    applyStimulus(0, 1, 0, 0, '0);
    checks++;
    if (emptyS !== 1'b1 || rdS !== 12'h000) begin
      errors++;
      $display("[TB] FAIL return_pop empty=%b rd=%h expected 1 000", emptyS, rdS);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    for (int v = 1; v <= 9; v++) applyStimulus(1, 0, 0, 0, 12'(v));
    repeat (3) applyStimulus(0, 1, 0, 0, '0);
    checks++;
    if (cntS !== 4'd5 || ovfS !== 1'b1 || rdS !== 12'd5) begin
      errors++;
      $display("[TB] FAIL pre_reset cnt=%0d ovf=%b rd=%0d expected 5 1 5", cntS, ovfS, rdS);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({rdS, cntS, fullS, emptyS, ovfS, unfS} !== {12'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset rd=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b expected 000 0 0 1 0 0",
               rdS, cntS, fullS, emptyS, ovfS, unfS);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_saturate();
    test_wrap();
    test_underflow();
    test_replace_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_stack.md
# call_stack

Parametrised return-address stack for the pipelined CPU, successor to the fixed 12-bit `stack` used by call/return instructions in ID. It stores up to DEPTH return addresses of WIDTH bits and exposes the top entry combinationally so the PC input mux can select it in the same cycle a return is decoded. It adds full/empty/count status, a selectable overflow policy, combined push+pop (replace-top), a synchronous flush for pipeline squash, and sticky overflow/underflow error flags.

## Interface
- WIDTH, 12, entry width in bits (PC width)
- DEPTH, 8, number of entries; power of two, ≥ 2
- OVF_MODE, 0, full-stack push policy: 0 = saturate (drop push), 1 = wrap (overwrite oldest)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- push  in  1  push writeData this cycle
- pop  in  1  pop top entry this cycle
- flush  in  1  empty the stack this cycle (pipeline squash)
- clrErr  in  1  clear sticky error flags
- writeData  in  WIDTH  value to push (PC+1 from IF/ID)
- readData  out  WIDTH  current top entry; 0 when empty
- count  out  $clog2(DEPTH+1)  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push seen while full
- underflow  out  1  sticky: pop seen while empty

## Operation
- State: storage array mem[DEPTH], write pointer ptr ($clog2(DEPTH) bits, modulo DEPTH), count, two sticky flags.
- Top entry is mem[ptr-1 mod DEPTH]; readData = empty ? 0 : top. Purely combinational from state.
- Priority per edge: flush > push/pop combination. Flush: ptr←0, count←0; push/pop that cycle ignored, no flags set.
- push only, not full: mem[ptr]←writeData, ptr←ptr+1, count←count+1.
- push only, full, OVF_MODE=0: no state change except overflow←1.
- push only, full, OVF_MODE=1: mem[ptr]←writeData, ptr←ptr+1 (overwrites oldest), count stays DEPTH, overflow←1.
- pop only, not empty: ptr←ptr-1, count←count-1; entry contents untouched.
- pop only, empty: no change, underflow←1.
- push+pop, not empty: replace top: mem[ptr-1]←writeData; ptr, count unchanged; no flags.
- push+pop, empty: behaves as push (count←1), underflow←1.
- clrErr: clears both flags; if a flag-setting event occurs the same cycle, set wins.
- Modulo arithmetic on ptr only; count never exceeds DEPTH nor goes below 0.

## Timing
- Reset (rst low, asynchronous): ptr=0, count=0, mem all zero, overflow=0, underflow=0 → readData=0, count=0, full=0, empty=1. Held while rst low; first update on first rising edge after release.
- readData/full/empty/count reflect state after the last edge; zero-latency read of top, one-cycle latency for push/pop effects.
- A value pushed at edge N is visible on readData after edge N; a return in the cycle after a call pops the just-pushed address.
- No handshake; push/pop are single-cycle strobes sampled every edge, legal on any cycle.

## Structure
- Shared package cpu_pkg: OVF_SATURATE=0, OVF_WRAP=1 constants; WIDTH default tied to the package PC-width constant.
- Single module, no sub-module; storage as a register array (small DEPTH, async-read needed).
- Replaces `stack` in the CPU top; the extra outputs feed the hazard/controller logic (underflow as illegal-return trap).

## Test plan
- Reset then push 0x010,0x020,0x030 → count=3, readData=0x030; pop ×3 → readData 0x020, 0x010, then 0, empty=1.
- DEPTH=8, OVF_MODE=0: push 1..9 → count=8, full=1, readData=8, overflow=1; pop ×8 returns 8..1.
- DEPTH=8, OVF_MODE=1: push 1..10 → count=8, readData=10, overflow=1; pop ×8 returns 10..3.
- Empty stack: pop → underflow=1, count=0; push+pop with writeData=0x055 → count=1, readData=0x055; clrErr → flags 0.
- Count=2 (0x100,0x200): push+pop writeData=0x2AA → count=2, readData=0x2AA, pop → 0x100; flush with push asserted → count=0, readData=0, no flag change.
- Assert rst low mid-sequence (count=5, overflow=1) asynchronously → outputs at reset values immediately, before next clock edge.
